rom_reader: RTL and testbench

Read-sequencing initiator for the 16x4 synchronous ROM. On a start pulse it reads `count` consecutive ROM words from `start_addr`, wrapping modulo 16. It drives the ROM's `en`/`addr` port, absorbs the ROM read latency, and streams the words out on a valid/ready interface with full backpressure. It sits between the ROM and any consumer, such as a display or serializer, and has a start/busy/done control handshake.

---
 rtl/rom_pkg.sv | 14 +
 rtl/rom_rd_fifo.sv | 56 +++++
 rtl/rom_reader.sv | 116 +++++++++++
 tb/tb_rom_reader.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/rom_pkg.sv
// Shared definitions for the ROM read sequencer: default widths, depth and FSM state type.
package rom_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 4;
  localparam int ROM_DEPTH  = 2 ** ADDR_W_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } rd_state_t;

endpackage

// File: rtl/rom_rd_fifo.sv
// Small synchronous FIFO that absorbs ROM read data until the consumer takes it.
// Depth need not be a power of two, so the pointers wrap explicitly.
module rom_rd_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] fill;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pop_ok = pop & (fill != '0);

  // Storage is cleared on reset so the head reads zero until the first push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      fill   <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= bump(wr_ptr);
      end
      if (pop_ok) rd_ptr <= bump(rd_ptr);
      case ({push, pop_ok})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (fill == '0);
  assign count = fill;

endmodule

// File: rtl/rom_reader.sv
// Read sequencer for a synchronous ROM: issues count consecutive reads (wrapping),
// buffers the returning words and streams them out on a valid/ready port.
module rom_reader
  import rom_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ROM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int FIFO_DEPTH = ROM_LAT + 1;
  localparam int OCC_W      = $clog2(FIFO_DEPTH + 1);

  rd_state_t         state;
  rd_state_t         state_nxt;
  logic [ADDR_W-1:0] addr_cnt;
  logic [ADDR_W:0]   issue_cnt;
  logic [ADDR_W:0]   accept_cnt;
  logic [ROM_LAT-1:0] in_flight;
  logic [3:0]        in_flight_n;
  logic [OCC_W-1:0]  occ;
  logic [3:0]        load;
  logic [3:0]        limit;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              issue;
  logic              take_start;

  assign take_start = (state == IDLE) && start;
  assign pop        = ~fifo_empty & out_ready;
  assign push       = in_flight[ROM_LAT-1];

  always_comb begin
    in_flight_n = '0;
    for (int i = 0; i < ROM_LAT; i++) in_flight_n = in_flight_n + {3'b000, in_flight[i]};
  end

  // A word leaving this cycle frees a slot, which keeps the stream bubble-free.
  assign load  = 4'(occ) + in_flight_n;
  assign limit = 4'(ROM_LAT + 1) + {3'b000, pop};
  assign issue = (state == RUN) && (issue_cnt != '0) && (load < limit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (count == '0) ? DONE : RUN;
      RUN:  if (pop && accept_cnt == 1) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_cnt   <= '0;
      issue_cnt  <= '0;
      accept_cnt <= '0;
      in_flight  <= '0;
    end else begin
      in_flight[0] <= issue;
      for (int i = 1; i < ROM_LAT; i++) in_flight[i] <= in_flight[i-1];
      if (take_start) begin
        addr_cnt   <= start_addr;
        issue_cnt  <= count;
        accept_cnt <= count;
      end else begin
        if (issue) begin
          addr_cnt  <= addr_cnt + 1'b1;
          issue_cnt <= issue_cnt - 1'b1;
        end
        if (pop && state == RUN) accept_cnt <= accept_cnt - 1'b1;
      end
    end
  end

  rom_rd_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(DATA_W)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .din  (rom_data),
    .pop  (pop),
    .head (out_data),
    .empty(fifo_empty),
    .count(occ)
  );

  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign rom_en    = issue;
  assign rom_addr  = addr_cnt;
  assign out_valid = ~fifo_empty;

endmodule

// File: tb/tb_rom_reader.sv
// Directed bench for rom_reader against a 1-cycle-latency ROM holding data[a] = a ^ 4'hA.
module tb_rom_reader;
  import rom_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] start_addr = '0;
  logic [4:0] count = '0;
  logic       busy, done, rom_en, out_valid;
  logic [3:0] rom_addr, rom_data, out_data;
  logic       out_ready = 1'b0;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0]  addr;
    logic [4:0]  cnt;
    bit          stall;
    logic [63:0] exp_data;
    logic [63:0] exp_addr;
  } vec_t;

  rom_reader #(.ADDR_W(4), .DATA_W(4), .ROM_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .count(count),
    .busy(busy), .done(done), .rom_en(rom_en), .rom_addr(rom_addr),
    .rom_data(rom_data), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Behavioural ROM, one cycle of read latency, unaffected by the reader's reset.
  always_ff @(posedge clk) begin
    if (rom_en) rom_data <= rom_addr ^ 4'hA;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one transaction from start to done and checks addresses, data, timing and handshakes.
  task automatic applyStimulus(input vec_t v, input string tag);
    int issued = 0, accepted = 0, cyc = 0, first_en = -1, done_cyc = -1, last_acc = -1;
    int max_out = 0, stall_err = 0, busy_err = 0, extra_err = 0;
    logic prev_stall = 1'b0;
    logic [3:0] prev_data = '0;
    bit seen_done = 0;
    @(negedge clk);
    start = 1'b1; start_addr = v.addr; count = v.cnt; out_ready = 1'b1;
    while (!seen_done && cyc < 200) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      out_ready = v.stall ? ((cyc % 3) == 0) : 1'b1;
      #1;
      if (prev_stall && (!out_valid || out_data !== prev_data)) stall_err++;
      if (done) begin
        seen_done = 1;
        done_cyc = cyc;
        if (busy) busy_err++;
      end else if (!busy) busy_err++;
      if (rom_en) begin
        if (issued == 0) first_en = cyc;
        if (issued < 16)
          checkOutput($sformatf("%s_rom_addr%0d", tag, issued), 32'(rom_addr), 32'(v.exp_addr[4*issued +: 4]));
        issued++;
      end
      if (out_valid && out_ready) begin
        if (accepted < 16)
          checkOutput($sformatf("%s_out_data%0d", tag, accepted), 32'(out_data), 32'(v.exp_data[4*accepted +: 4]));
        accepted++;
        last_acc = cyc;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (issued - accepted > max_out) max_out = issued - accepted;
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      if (out_valid || rom_en || done || busy) extra_err++;
    end
    checkOutput({tag, "_done_seen"}, 32'(seen_done), 32'd1);
    checkOutput({tag, "_accepts"}, 32'(accepted), 32'(v.cnt));
    checkOutput({tag, "_issues"}, 32'(issued), 32'(v.cnt));
    checkOutput({tag, "_first_en_cycle"}, 32'(first_en), 32'd1);
    checkOutput({tag, "_done_after_last"}, 32'(done_cyc), 32'(last_acc + 1));
    checkOutput({tag, "_outstanding_le2"}, 32'(max_out <= 2), 32'd1);
    checkOutput({tag, "_stall_stable_errs"}, 32'(stall_err), 32'd0);
    checkOutput({tag, "_busy_errs"}, 32'(busy_err), 32'd0);
    checkOutput({tag, "_quiet_after_done"}, 32'(extra_err), 32'd0);
    if (!v.stall) checkOutput({tag, "_done_cycle"}, 32'(done_cyc), 32'(v.cnt) + 32'd3);
  endtask

  initial begin
    vec_t vecs[5];
    int   acc, errs, cyc;
    vecs[0] = '{4'd2,  5'd4,  1'b0, 64'hFE98,             64'h5432};
    vecs[1] = '{4'd14, 5'd4,  1'b0, 64'hBA54,             64'h10FE};
    vecs[2] = '{4'd0,  5'd16, 1'b1, 64'h54761032DCFE98BA, 64'hFEDCBA9876543210};
    vecs[3] = '{4'd7,  5'd1,  1'b0, 64'hD,                64'h7};
    vecs[4] = '{4'd15, 5'd16, 1'b0, 64'h4761032DCFE98BA5, 64'hEDCBA9876543210F};

    // Outputs must be quiet while reset is held, before any clock edge.
    #3;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_rom_en", 32'(rom_en), 32'd0);
    checkOutput("reset_rom_addr", 32'(rom_addr), 32'd0);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_out_data", 32'(out_data), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;

    for (int i = 0; i < 5; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // Zero-length request: done pulses next cycle with no ROM access.
    @(negedge clk);
    start = 1'b1; start_addr = 4'd9; count = 5'd0;
    #1;
    checkOutput("zero_rom_en_c0", 32'(rom_en), 32'd0);
    @(negedge clk);
    start = 1'b0;
    #1;
    checkOutput("zero_done_c1", 32'(done), 32'd1);
    checkOutput("zero_busy_c1", 32'(busy), 32'd0);
    checkOutput("zero_rom_en_c1", 32'(rom_en), 32'd0);
    @(negedge clk);
    #1;
    checkOutput("zero_done_c2", 32'(done), 32'd0);
    checkOutput("zero_rom_en_c2", 32'(rom_en), 32'd0);

    // A second start while running must be ignored.
    @(negedge clk);
    start = 1'b1; start_addr = 4'd3; count = 5'd2;
    acc = 0;
    for (cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      start = (cyc == 2);
      start_addr = (cyc == 2) ? 4'd9 : 4'd3;
      count = (cyc == 2) ? 5'd5 : 5'd2;
      #1;
      if (out_valid && out_ready) begin
        checkOutput($sformatf("restart_data%0d", acc), 32'(out_data), (acc == 0) ? 32'h9 : 32'hE);
        acc++;
      end
      if (cyc == 5) checkOutput("restart_done_c5", 32'(done), 32'd1);
    end
    start = 1'b0;
    checkOutput("restart_accepts", 32'(acc), 32'd2);

    // Reset in the middle of an 8-word read after three accepts.
    @(negedge clk);
    start = 1'b1; start_addr = 4'd0; count = 5'd8;
    acc = 0;
    cyc = 0;
    while (acc < 3 && cyc < 50) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      #1;
      if (out_valid && out_ready) acc++;
    end
    checkOutput("midrst_accepts_before", 32'(acc), 32'd3);
    @(posedge clk);
    #1;
    checkOutput("midrst_busy_before", 32'(busy), 32'd1);
    checkOutput("midrst_rom_en_before", 32'(rom_en), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_rom_en", 32'(rom_en), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    errs = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      if (out_valid || busy || rom_en || done) errs++;
    end
    checkOutput("midrst_no_stale", 32'(errs), 32'd0);
    applyStimulus('{4'd5, 5'd2, 1'b0, 64'hCF, 64'h65}, "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
